eprisc_irq_controller: RTL

//  Prioritised interrupt controller downstream of the GPIO controllers and other epRISC I/O modules.
//  - Collects up to SOURCES single-bit interrupt lines, such as each GPIO block's oInterrupt.
//  - Latches them as pending, masks them, and presents the highest-priority request to the CPU.
//  - Runs a request/acknowledge/end-of-interrupt handshake with the CPU.
//  - Register file sits on the same 2-bit-address, 16-bit-data I/O bus as the other I/O modules.
//

---
 rtl/eprisc_irq_pkg.sv | 19 +
 rtl/eprisc_irq_prio_enc.sv | 23 ++
 rtl/eprisc_irq_controller.sv | 132 +++++++++++++
 3 files changed

// File: rtl/eprisc_irq_pkg.sv
// Shared constants for the epRISC interrupt controller: register map, FSM encoding and
// STATUS bit positions.
package eprisc_irq_pkg;

    localparam logic [1:0] REG_MASK    = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam int unsigned STATUS_IN_SERVICE = 15;
    localparam int unsigned STATUS_IRQ        = 14;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SERVICE
    } irqState_t;

endpackage

// File: rtl/eprisc_irq_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of iReq and whether any bit is set.
module eprisc_irq_prio_enc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]         iReq,
    output logic [$clog2(WIDTH)-1:0] oWin,
    output logic                     oAny
);

    localparam int unsigned VEC_W = $clog2(WIDTH);

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        oWin = '0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (iReq[i]) begin
                oWin = VEC_W'(i);
            end
        end
        oAny = |iReq;
    end

endmodule

// File: rtl/eprisc_irq_controller.sv
// Prioritised interrupt controller on the epRISC 2-bit-address I/O bus: latches sources as
// pending, masks them and runs a request/ack/EOI handshake with the CPU.
module eprisc_irq_controller
    import eprisc_irq_pkg::*;
#(
    parameter int unsigned SOURCES = 8
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic [SOURCES-1:0]         iSource,
    input  logic [1:0]                 iAddress,
    input  logic [15:0]                iData,
    output logic [15:0]                oData,
    input  logic                       iWrite,
    input  logic                       iEnable,
    output logic                       oIrq,
    output logic [$clog2(SOURCES)-1:0] oVector,
    input  logic                       iAck
);

    localparam int unsigned VEC_W = $clog2(SOURCES);

    logic [SOURCES-1:0] rMask, rPending, rEdge, rPrev;
    logic [SOURCES-1:0] pendingNext, wrData, edgeDet, modeChange, w1c, ackClear, req;
    logic [VEC_W-1:0]   rVector, vectorNext, win;
    irqState_t          rState, stateNext;
    logic               busWrite, eoi, ackTaken, reqAny;
    logic               unusedData;

    assign busWrite   = iEnable && iWrite;
    assign wrData     = iData[SOURCES-1:0];
    assign unusedData = ^(iData >> SOURCES);
    assign eoi        = busWrite && (iAddress == REG_STATUS);
    assign ackTaken   = (rState == REQUEST) && iAck;

    assign edgeDet    = iSource & ~rPrev;
    assign w1c        = (busWrite && iAddress == REG_PENDING) ? wrData : '0;
    assign modeChange = (busWrite && iAddress == REG_EDGE) ? (wrData ^ rEdge) : '0;
    assign ackClear   = ackTaken ? (SOURCES'(1) << rVector) : '0;

    // Bits switching mode hold for one cycle; edge bits set-wins over W1C/ack; level bits track.
    assign pendingNext = (modeChange & rPending)
                       | (~modeChange & rEdge & (edgeDet | (rPending & ~w1c & ~ackClear)))
                       | (~modeChange & ~rEdge & iSource);

    assign req = rPending & rMask;

    eprisc_irq_prio_enc #(
        .WIDTH(SOURCES)
    ) uPrioEnc (
        .iReq(req),
        .oWin(win),
        .oAny(reqAny)
    );

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            rMask    <= '0;
            rPending <= '0;
            rEdge    <= '0;
            rPrev    <= '0;
        end else begin
            rPrev    <= iSource;
            rPending <= pendingNext;
            if (busWrite && iAddress == REG_MASK) begin
                rMask <= wrData;
            end
            if (busWrite && iAddress == REG_EDGE) begin
                rEdge <= wrData;
            end
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            rState  <= IDLE;
            rVector <= '0;
        end else begin
            rState  <= stateNext;
            rVector <= vectorNext;
        end
    end

    always_comb begin
        stateNext  = rState;
        vectorNext = rVector;
        unique case (rState)
            IDLE: begin
                if (reqAny) begin
                    stateNext  = REQUEST;
                    vectorNext = win;
                end
            end
            REQUEST: begin
                if (iAck) begin
                    stateNext = SERVICE;
                end else if (!rMask[rVector]) begin
                    stateNext = IDLE;
                end
            end
            SERVICE: begin
                if (eoi) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        oIrq    = (rState == REQUEST);
        oVector = rVector;
    end

    always_comb begin
        oData = '0;
        if (iEnable && !iWrite) begin
            unique case (iAddress)
                REG_MASK:    oData = 16'(rMask);
                REG_PENDING: oData = 16'(rPending);
                REG_EDGE:    oData = 16'(rEdge);
                REG_STATUS: begin
                    oData[STATUS_IN_SERVICE] = (rState == SERVICE);
                    oData[STATUS_IRQ]        = (rState == REQUEST);
                    oData[VEC_W-1:0]         = rVector;
                end
                default: oData = '0;
            endcase
        end
    end

endmodule
